// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
// Holds the 3-bit FSM state encoding, the default operand width and a
// helper that sizes the iteration counter.
package mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int WIDTH_DEF = 3;

    // Width of the state encoding.
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Counter width able to hold 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_fsm.sv
// Sequencer for the shift-and-add multiplier.
// Owns the state register and the registered busy/done_mult outputs.
// The datapath tells it the multiplier LSB and whether the current SHIFT
// is the final iteration; it reports the current state back and flags the
// SHIFT cycle whose edge enters DONE so the result can be captured there.
module mult_fsm
    import mult_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   init_mult,
    input  logic   b_lsb,
    input  logic   last_iter,
    output state_t state,
    output logic   enter_done,
    output logic   done_mult,
    output logic   busy
);

    // High during the SHIFT cycle whose closing edge moves the FSM into DONE.
    assign enter_done = (state == ST_SHIFT) && last_iter;

    // State register with registered busy and one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            done_mult <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done_mult <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // init_mult is only looked at here, so requests made
                    // while busy are simply dropped.
                    if (init_mult) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    state <= b_lsb ? ST_ADD : ST_SHIFT;
                end
                ST_ADD: begin
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (last_iter) begin
                        state     <= ST_DONE;
                        done_mult <= 1'b1;
                    end else begin
                        state <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mult_ctrl.sv
// Shift-and-add unsigned multiplier, top level.
// Holds the datapath (a_reg, b_reg, acc, cnt) and the result register
// sal_mult; sequencing lives in mult_fsm.
// Optional feature: define MULT_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero. Without it every operation runs
// exactly WIDTH CHECK/SHIFT iterations, giving a latency that depends only
// on the popcount of portB.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   portA,
    input  logic [WIDTH-1:0]   portB,
    input  logic               init_mult,
    output logic [2*WIDTH-1:0] sal_mult,
    output logic               done_mult,
    output logic               busy
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [PROD_W-1:0] a_reg;
    logic [PROD_W-1:0] acc;
    logic [WIDTH-1:0]  b_reg;
    logic [CNT_W-1:0]  cnt;

    state_t state;
    logic   enter_done;
    logic   cnt_last;
    logic   last_iter;

    assign cnt_last = (cnt == CNT_LAST);

`ifdef MULT_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain after this shift; further
    // iterations could only add zero.
    assign last_iter = cnt_last || ((b_reg >> 1) == '0);
`else
    assign last_iter = cnt_last;
`endif

    mult_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .init_mult  (init_mult),
        .b_lsb      (b_reg[0]),
        .last_iter  (last_iter),
        .state      (state),
        .enter_done (enter_done),
        .done_mult  (done_mult),
        .busy       (busy)
    );

    // Datapath registers: operands are captured only in LOAD, so input
    // changes during the operation cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    a_reg <= {{WIDTH{1'b0}}, portA};
                    b_reg <= portB;
                    acc   <= '0;
                    cnt   <= '0;
                end
                ST_ADD: begin
                    // Product fits in PROD_W bits, so the carry-out is dropped.
                    acc <= acc + a_reg;
                end
                ST_SHIFT: begin
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: begin
                    a_reg <= a_reg;
                end
            endcase
        end
    end

    // Result register: loaded on the edge that enters DONE, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sal_mult <= '0;
        end else if (enter_done) begin
            sal_mult <= acc;
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a scoreboard of expected products and
// completion edges, checked whenever done_mult is seen.
module tb_mult_ctrl;

    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   portA;
    logic [W-1:0]   portB;
    logic           init_mult;
    logic [2*W-1:0] sal_mult;
    logic           done_mult;
    logic           busy;

    mult_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .portA     (portA),
        .portB     (portB),
        .init_mult (init_mult),
        .sal_mult  (sal_mult),
        .done_mult (done_mult),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; at a falling edge this equals the
    // index of the edge just taken.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] prod;
        int             done_edge;
    } exp_t;

    exp_t sb[$];

    int total    = 0;
    int passed   = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Edges from the init sampling edge to the edge that enters DONE.
    function automatic int lat(input logic [W-1:0] b);
        int n;
`ifdef MULT_EARLY_EXIT_EN
        logic [W-1:0] bb;
        bb = b;
        n  = 1;
        for (int i = 0; i < W; i++) begin
            n = n + 1 + int'(bb[0]) + 1;
            bb = bb >> 1;
            if (bb == '0) break;
        end
`else
        n = 1 + 2 * W + $countones(b);
`endif
        return n;
    endfunction

    function automatic logic [2*W-1:0] prod_of(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    // Called just after a falling edge: one-cycle init pulse.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        portA     = a;
        portB     = b;
        init_mult = 1'b1;
        e.prod      = prod_of(a, b);
        e.done_edge = cyc + 1 + lat(b);
        sb.push_back(e);
        @(negedge clk);
        init_mult = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("idle_within_budget", 64'(n < budget), 64'd1);
        sb.delete();
    endtask

    // Scoreboard consumer: every done pulse must match the oldest entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done_mult === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("product", 64'(sal_mult), 64'(e.prod));
                check("done_edge", 64'(cyc), 64'(e.done_edge));
            end
        end
    end

    initial begin : stim
        int d0;
        int n;
        rst       = 1'b1;
        init_mult = 1'b0;
        portA     = '0;
        portB     = '0;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("rst_sal_mult", 64'(sal_mult), 64'd0);
        check("rst_done", 64'(done_mult), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // 5*3
        launch(3'd5, 3'd3);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_idle(40);

        // 7*7, the longest operation
        launch(3'd7, 3'd7);
        wait_idle(40);

        // 6*0 and 0*5: zero results
        launch(3'd6, 3'd0);
        wait_idle(40);
        launch(3'd0, 3'd5);
        wait_idle(40);

        // 4*6 for another bit pattern
        launch(3'd4, 3'd6);
        wait_idle(40);

        // Request and operand change while busy must be ignored.
        d0 = done_cnt;
        launch(3'd5, 3'd3);
        repeat (2) @(negedge clk);
        init_mult = 1'b1;
        portA     = 3'd2;
        portB     = 3'd7;
        @(negedge clk);
        init_mult = 1'b0;
        wait_idle(40);
        repeat (12) @(negedge clk);
        #1;
        check("ignored_init_done_count", 64'(done_cnt - d0), 64'd1);

        // init held high: two back-to-back 3*2 operations.
        d0        = done_cnt;
        portA     = 3'd3;
        portB     = 3'd2;
        init_mult = 1'b1;
        begin
            exp_t e;
            e.prod      = prod_of(3'd3, 3'd2);
            e.done_edge = cyc + 1 + lat(3'd2);
            sb.push_back(e);
            e.done_edge = e.done_edge + 2 + lat(3'd2);
            sb.push_back(e);
        end
        n = 0;
        while (done_cnt < d0 + 2 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("b2b_within_budget", 64'(n < 40), 64'd1);
        init_mult = 1'b0;
        wait_idle(40);
        repeat (12) @(negedge clk);
        #1;
        check("b2b_done_count", 64'(done_cnt - d0), 64'd2);
        check("b2b_result_held", 64'(sal_mult), 64'd6);

        // Reset three edges into a 7*7 operation aborts it.
        d0 = done_cnt;
        launch(3'd7, 3'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done_mult), 64'd0);
        check("abort_sal_mult", 64'(sal_mult), 64'd0);
        sb.delete();
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        // Normal operation after the abort.
        launch(3'd6, 3'd5);
        wait_idle(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
